vx_cache_tag_ctrl: RTL
======================

// Module: vx_cache_tag_ctrl
// PURPOSE
//  Drives the command side of a cache bank's tag store: lookup, fill, init, addr and stall.
//  After reset it sweeps every line of the bank with init. It also runs the same sweep on a flush request.
//  Outside a sweep it arbitrates memory-fill responses against core lookups, one tag command per cycle.
//  Sits between the bank's request/fill queues and the tag store. It owns all tag-store sequencing.
// PARAMETERS
//  INSTANCE_ID  ""  trace identifier string
//  BANK_ID      0   bank index, used for trace output only
//  CACHE_SIZE   1024  cache size in bytes
//  LINE_SIZE    16  line size in bytes
//  NUM_BANKS    1   number of banks
//  NUM_WAYS     1   associativity; passed through for trace only
//  WORD_SIZE    4   word size in bytes
//  UUID_WIDTH   0   request debug id width; the port uses `UP(UUID_WIDTH)
// PORTS
//  clk          in   1                   clock
//  reset        in   1                   asynchronous reset, active-high
//  pipe_stall   in   1                   downstream bank pipeline stall
//  req_valid    in   1                   core lookup request valid
//  req_addr     in   `LINE_ADDR_WIDTH    core lookup line address
//  req_uuid     in   `UP(UUID_WIDTH)     core request debug id
//  req_ready    out  1                   core lookup accepted
//  fill_valid   in   1                   memory fill response valid
//  fill_addr    in   `LINE_ADDR_WIDTH    fill line address
//  fill_ready   out  1                   fill accepted
//  flush_valid  in   1                   flush request; held high until acked
//  flush_ready  out  1                   flush ack; high on the last line of a flush sweep
//  busy         out  1                   an init sweep is in progress
//  tag_lookup   out  1                   tag store lookup
//  tag_fill     out  1                   tag store fill
//  tag_init     out  1                   tag store init (invalidate)
//  tag_addr     out  `LINE_ADDR_WIDTH    tag store line address
//  tag_uuid     out  `UP(UUID_WIDTH)     uuid forwarded with the lookup
//  tag_stall    out  1                   equals pipe_stall
// BEHAVIOUR
//  Reset and clocking
//  - One clock. Reset is asynchronous and active-high.
//  - Reset puts the block in state INIT with the line counter at 0. busy=1; all handshake outputs are 0.
//  State machine: INIT, IDLE, FLUSH; counter cnt has `LINE_SEL_BITS bits
//  - INIT/FLUSH: tag_init=1 and tag_addr={0, cnt} every cycle, independent of pipe_stall.
//    tag_fill=0, tag_lookup=0, req_ready=0, fill_ready=0.
//  - The counter increments each sweep cycle. At cnt==`LINES_PER_BANK-1 it wraps to 0 and the state goes to IDLE.
//  - A sweep therefore takes exactly `LINES_PER_BANK cycles.
//  - FLUSH only: flush_ready=1 in the last sweep cycle. It is a single-cycle ack.
//  - The reset sweep never asserts flush_ready.
//    A flush_valid that arrives during the reset sweep is served by a new FLUSH sweep entered from IDLE.
//  - IDLE priority: fill > flush > lookup. Decisions are combinational, so command latency is 0 cycles.
//  - IDLE fill: fill_ready=~pipe_stall.
//    When fill_valid=1, drive tag_fill=fill_valid&~pipe_stall and tag_addr=fill_addr.
//  - IDLE flush: flush_valid&~fill_valid moves to FLUSH next cycle with cnt=0.
//    No lookup is accepted in that cycle.
//  - IDLE lookup: req_ready=~pipe_stall&~fill_valid&~flush_valid.
//    tag_lookup=req_valid&req_ready; tag_addr=req_addr; tag_uuid=req_uuid.
//  - When pipe_stall=1 in IDLE: tag_fill=0 and tag_lookup=0, and tag_addr keeps the selected source.
//    This lets the tag store hold its replacement state and avoid a double fill.
//  - busy=1 exactly in INIT and FLUSH.
//  - Reset asserted mid-sweep: the sweep restarts at line 0 in INIT.
//    Any pending flush ack is dropped, so the requester keeps flush_valid high.
//  - Upper address bits are don't-care during sweeps and are driven to 0.
// STRUCTURE
//  - State encoding and the sweep-count constant live in the shared cache package
//    (VX_cache_define.vh / cache pkg), next to `LINES_PER_BANK and `LINE_SEL_BITS.
//  - No sub-module. The counter and the arbiter are inline.
//  - Tracing follows the DBG_TRACE_CACHE_TAG convention.
// TESTING  (CACHE_SIZE=1024, LINE_SIZE=16, NUM_BANKS=1 -> 64 lines)
//  - Reset release -> tag_init=1 for 64 cycles, addr 0..63.
//    busy falls on cycle 64; flush_ready never asserts.
//  - IDLE, fill_valid=1, addr=0x2A, req_valid=1 -> tag_fill=1, tag_addr=0x2A, fill_ready=1, req_ready=0.
//  - IDLE, pipe_stall=1, fill_valid=1 -> tag_fill=0 and fill_ready=0 until the stall drops,
//    then a single fill cycle.
//  - flush_valid in IDLE -> 64 init cycles with flush_ready=1 only at addr 63.
//    Lookups are blocked for the whole sweep.
//  - Reset pulsed at sweep line 20 -> the sweep restarts from 0 and totals 64 cycles after release.
//  - req_valid=1, addr=0x11, uuid=5 -> tag_lookup=1, tag_addr=0x11, tag_uuid=5 in the same cycle.

Source files
------------

// File: rtl/vx_cache_tag_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_cache_tag_ctrl_pkg                                                      |
// | Shared cache-bank constants, sweep sizing helpers and tag controller state |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package vx_cache_tag_ctrl_pkg;

    localparam int MEM_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } tag_state_e;

    function automatic int lines_per_bank(int cache_size, int line_size, int num_banks);
        return cache_size / (line_size * num_banks);
    endfunction

    function automatic int line_addr_width(int line_size);
        return MEM_ADDR_WIDTH - $clog2(line_size);
    endfunction

    // Zero-width fields still need one physical bit on a port.
    function automatic int up(int width);
        return (width > 0) ? width : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_cache_tag_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_cache_tag_ctrl_if                                                       |
// | Request/fill/flush handshakes and tag-store command bus of a cache bank    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vx_cache_tag_ctrl_if
    import vx_cache_tag_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = line_addr_width(16),
    parameter int UUID_WIDTH = up(0)
);
    logic                  pipe_stall;
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [UUID_WIDTH-1:0] req_uuid;
    logic                  req_ready;
    logic                  fill_valid;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  fill_ready;
    logic                  flush_valid;
    logic                  flush_ready;
    logic                  busy;
    logic                  tag_lookup;
    logic                  tag_fill;
    logic                  tag_init;
    logic [ADDR_WIDTH-1:0] tag_addr;
    logic [UUID_WIDTH-1:0] tag_uuid;
    logic                  tag_stall;

    modport master (
        output pipe_stall, req_valid, req_addr, req_uuid, fill_valid, fill_addr, flush_valid,
        input  req_ready, fill_ready, flush_ready, busy,
        input  tag_lookup, tag_fill, tag_init, tag_addr, tag_uuid, tag_stall
    );

    modport slave (
        input  pipe_stall, req_valid, req_addr, req_uuid, fill_valid, fill_addr, flush_valid,
        output req_ready, fill_ready, flush_ready, busy,
        output tag_lookup, tag_fill, tag_init, tag_addr, tag_uuid, tag_stall
    );

endinterface
`default_nettype wire

// File: rtl/vx_cache_tag_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vx_cache_tag_ctrl                                                          |
// | Tag-store sequencer: init/flush sweeps, fill-over-lookup arbitration       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vx_cache_tag_ctrl
    import vx_cache_tag_ctrl_pkg::*;
#(
    parameter string INSTANCE_ID = "",
    parameter int    BANK_ID     = 0,
    parameter int    CACHE_SIZE  = 1024,
    parameter int    LINE_SIZE   = 16,
    parameter int    NUM_BANKS   = 1,
    parameter int    NUM_WAYS    = 1,
    parameter int    WORD_SIZE   = 4,
    parameter int    UUID_WIDTH  = 0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    vx_cache_tag_ctrl_if.slave bus
);

    localparam int LINES_PER_BANK  = lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS);
    localparam int LINE_SEL_BITS   = up($clog2(LINES_PER_BANK));
    localparam int LINE_ADDR_WIDTH = line_addr_width(LINE_SIZE);
    localparam logic [LINE_SEL_BITS-1:0] LAST_LINE = LINE_SEL_BITS'(LINES_PER_BANK - 1);

    if (NUM_WAYS < 1 || WORD_SIZE < 1 || (LINE_SIZE % WORD_SIZE) != 0 ||
        BANK_ID >= NUM_BANKS || UUID_WIDTH < 0 || LINES_PER_BANK < 2) begin : g_bad_params
        $error("vx_cache_tag_ctrl: inconsistent cache geometry parameters");
    end

    tag_state_e               state;
    logic [LINE_SEL_BITS-1:0] cnt;
    logic                     sweep_last;

    assign sweep_last = (cnt == LAST_LINE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_INIT, ST_FLUSH: begin
                    if (sweep_last) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // A pending fill always wins; the flush waits for a fill-free cycle.
                    if (!bus.fill_valid && bus.flush_valid) begin
                        cnt   <= '0;
                        state <= ST_FLUSH;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_INIT;
                end
            endcase
        end
    end

    logic                       req_ready;
    logic                       fill_ready;
    logic                       flush_ready;
    logic                       busy;
    logic                       tag_lookup;
    logic                       tag_fill;
    logic                       tag_init;
    logic [LINE_ADDR_WIDTH-1:0] tag_addr;

    always_comb begin
        req_ready   = 1'b0;
        fill_ready  = 1'b0;
        flush_ready = 1'b0;
        busy        = 1'b0;
        tag_lookup  = 1'b0;
        tag_fill    = 1'b0;
        tag_init    = 1'b0;
        tag_addr    = '0;
        if (state == ST_IDLE) begin
            fill_ready = ~bus.pipe_stall;
            req_ready  = ~bus.pipe_stall & ~bus.fill_valid & ~bus.flush_valid;
            tag_fill   = bus.fill_valid & ~bus.pipe_stall;
            tag_lookup = bus.req_valid & req_ready;
            // Address follows the selected source even while stalled.
            tag_addr   = bus.fill_valid ? bus.fill_addr : bus.req_addr;
        end else begin
            busy        = 1'b1;
            tag_init    = 1'b1;
            tag_addr    = LINE_ADDR_WIDTH'(cnt);
            flush_ready = (state == ST_FLUSH) && sweep_last;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.fill_ready  = fill_ready;
    assign bus.flush_ready = flush_ready;
    assign bus.busy        = busy;
    assign bus.tag_lookup  = tag_lookup;
    assign bus.tag_fill    = tag_fill;
    assign bus.tag_init    = tag_init;
    assign bus.tag_addr    = tag_addr;
    assign bus.tag_uuid    = bus.req_uuid;
    assign bus.tag_stall   = bus.pipe_stall;

endmodule
`default_nettype wire
